// File: rtl/vdecode_pkg.sv
// Shared definitions for the vector decoder: opcodes, execute-stage op codes,
// the registered control word, and the per-opcode classification helpers.
package vdecode_pkg;

    // 5-bit opcodes; 16..31 are unassigned and decode as illegal
    localparam logic [4:0] OP_NOOP  = 5'd0,  OP_ADD   = 5'd1,  OP_SUB   = 5'd2,  OP_XOR   = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4,  OP_ORR   = 5'd5,  OP_LDV_I = 5'd6,  OP_LDV_R = 5'd7;
    localparam logic [4:0] OP_STR_I = 5'd8,  OP_STR_R = 5'd9,  OP_MOVS  = 5'd10, OP_MOVV  = 5'd11;
    localparam logic [4:0] OP_SLV   = 5'd12, OP_SRV   = 5'd13, OP_ROL   = 5'd14, OP_ROR   = 5'd15;

    localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_SL  = 4'd6, ALU_SR  = 4'd7;
    localparam logic [3:0] ALU_ROL = 4'd8, ALU_ROR = 4'd9, ALU_MOV = 4'd10;

    localparam logic [2:0] MEM_NOP = 3'd0, MEM_LDV_I = 3'd1, MEM_LDV_R = 3'd2;
    localparam logic [2:0] MEM_STR_I = 3'd3, MEM_STR_R = 3'd4;

    // ADD_EXT: base + immediate, ADD_REG: register address, MOV: scalar move
    localparam logic [1:0] INTU_NOP = 2'd0, INTU_ADD_EXT = 2'd1, INTU_ADD_REG = 2'd2, INTU_MOV = 2'd3;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] mem_op;
        logic [1:0] intu_op;
        logic       vop_sel;
        logic       ex_res_sel;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic writer;
        logic reader;
    } vk_class_t;

    // Control word for one opcode; imm_flag only matters for shifts/rotates
    function automatic ctrl_t decode_op(input logic [4:0] op, input logic imm_flag);
        ctrl_t c;
        c = '0;
        case (op)
            OP_NOOP:  ;
            OP_ADD:   c.alu_op = ALU_ADD;
            OP_SUB:   c.alu_op = ALU_SUB;
            OP_XOR:   c.alu_op = ALU_XOR;
            OP_AND:   c.alu_op = ALU_AND;
            OP_ORR:   c.alu_op = ALU_OR;
            OP_LDV_I: begin c.mem_op = MEM_LDV_I; c.intu_op = INTU_ADD_EXT; c.ex_res_sel = 1'b1; end
            OP_LDV_R: begin c.mem_op = MEM_LDV_R; c.intu_op = INTU_ADD_REG; c.ex_res_sel = 1'b1; end
            OP_STR_I: begin c.mem_op = MEM_STR_I; c.intu_op = INTU_ADD_EXT; c.ex_res_sel = 1'b1; end
            OP_STR_R: begin c.mem_op = MEM_STR_R; c.intu_op = INTU_ADD_REG; c.ex_res_sel = 1'b1; end
            OP_MOVS:  begin c.intu_op = INTU_MOV; c.ex_res_sel = 1'b1; end
            OP_MOVV:  c.alu_op = ALU_MOV;
            OP_SLV:   begin c.alu_op = ALU_SL;  c.vop_sel = imm_flag; end
            OP_SRV:   begin c.alu_op = ALU_SR;  c.vop_sel = imm_flag; end
            OP_ROL:   begin c.alu_op = ALU_ROL; c.vop_sel = imm_flag; end
            OP_ROR:   begin c.alu_op = ALU_ROR; c.vop_sel = imm_flag; end
            default:  c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // How an opcode touches its vector register vk (writers also read it)
    function automatic vk_class_t vk_class(input logic [4:0] op);
        vk_class_t k;
        k = '0;
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_ORR, OP_LDV_I, OP_LDV_R,
            OP_MOVV, OP_SLV, OP_SRV, OP_ROL, OP_ROR: begin k.writer = 1'b1; k.reader = 1'b1; end
            OP_STR_I, OP_STR_R:                      k.reader = 1'b1;
            default:                                 ;
        endcase
        return k;
    endfunction

    // {uses immediate, uses scalar register rk}
    function automatic logic [1:0] field_use(input logic [4:0] op);
        logic [1:0] u;
        u = 2'b00;
        case (op)
            OP_LDV_I, OP_LDV_R, OP_STR_I, OP_STR_R, OP_MOVS: u = 2'b11;
            OP_MOVV:                                         u = 2'b01;
            default:                                         ;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/vdecode_scoreboard.sv
// Per-vector-register busy bits: set on issue of a writer, cleared by
// writeback, wiped by flush. A same-cycle set and clear leaves the bit set.
module vdecode_scoreboard #(
    parameter int NVREG = 16,
    parameter int VW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          set_en,
    input  logic [VW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [VW-1:0] clr_idx,
    input  logic [VW-1:0] rd_idx,
    output logic          rd_busy
);

    logic [NVREG-1:0] busy, busy_nxt;

    // Next busy vector: clear first so a simultaneous set takes priority
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_idx] = 1'b0;
        if (set_en) busy_nxt[set_idx] = 1'b1;
        if (flush)  busy_nxt = '0;
    end

    // Busy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    // Registered lookup only: a writeback this cycle does not bypass
    assign rd_busy = busy[rd_idx];

endmodule

// File: rtl/vdecode_pipe.sv
// Pipelined vector instruction decoder: one register stage between fetch and
// execute, valid/ready on both sides. Build option VDECODE_SCOREBOARD_EN adds
// the vector-register busy scoreboard and RAW/WAW stall.
module vdecode_pipe
    import vdecode_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int ELEM_W = 8,
    parameter int NVREG  = 16,
    parameter int IMM_W  = 19,
    localparam int VW    = (NVREG > 1) ? $clog2(NVREG) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             instruction,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IMM_W-1:0]        imm,
    output logic [3:0]              alu_op,
    output logic [2:0]              mem_op,
    output logic [1:0]              intu_op,
    output logic [VW-1:0]           vk_reg,
    output logic [3:0]              rk_reg,
    output logic [LANES*ELEM_W-1:0] v_operand,
    output logic                    deco_vop_sel,
    output logic                    ex_res_sel,
    output logic                    illegal,
    input  logic                    wb_valid,
    input  logic [VW-1:0]           wb_vreg
);

    logic [4:0]    opcode;
    logic [VW-1:0] vk_idx;
    logic [3:0]    rk_idx;
    ctrl_t         dec;
    vk_class_t     cls;
    logic [1:0]    use_f;
    logic          hazard, accept;

    assign opcode = instruction[31:27];
    assign vk_idx = instruction[23 +: VW];
    assign rk_idx = instruction[22:19];
    assign dec    = decode_op(opcode, instruction[14]);
    assign cls    = vk_class(opcode);
    assign use_f  = field_use(opcode);

`ifdef VDECODE_SCOREBOARD_EN
    logic vk_busy;

    vdecode_scoreboard #(.NVREG(NVREG), .VW(VW)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .set_en  (accept & cls.writer),
        .set_idx (vk_idx),
        .clr_en  (wb_valid),
        .clr_idx (wb_vreg),
        .rd_idx  (vk_idx),
        .rd_busy (vk_busy)
    );

    assign hazard = in_valid & cls.reader & vk_busy;
`else
    logic unused_sb;
    assign unused_sb = ^{wb_valid, wb_vreg, cls};
    assign hazard    = 1'b0;
`endif

    assign in_ready = ~hazard & (~out_valid | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;

    // Output register: load on accept, hold while stalled, drop valid when consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            alu_op       <= '0;
            mem_op       <= '0;
            intu_op      <= '0;
            deco_vop_sel <= 1'b0;
            ex_res_sel   <= 1'b0;
            illegal      <= 1'b0;
            imm          <= '0;
            vk_reg       <= '0;
            rk_reg       <= '0;
            v_operand    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            alu_op       <= dec.alu_op;
            mem_op       <= dec.mem_op;
            intu_op      <= dec.intu_op;
            deco_vop_sel <= dec.vop_sel;
            ex_res_sel   <= dec.ex_res_sel;
            illegal      <= dec.illegal;
            imm          <= use_f[1]   ? instruction[IMM_W-1:0] : '0;
            vk_reg       <= cls.reader ? vk_idx : '0;
            rk_reg       <= use_f[0]   ? rk_idx : '0;
            v_operand    <= dec.vop_sel ? {LANES{instruction[ELEM_W-1:0]}} : '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
